// File: rtl/dec38_pkg.sv
// dec38_pkg: shared state encoding, idle pattern and one-cold helper for decoder3_8_reg.
package dec38_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
    localparam logic [7:0] Y_OFF = 8'hFF;
    function automatic logic [7:0] one_cold(input logic [2:0] i);
        return ~(8'b1 << i);
    endfunction
endpackage

// File: rtl/decoder3_8_reg_scan_tick_gen.sv
// scan_tick_gen: free-running 0..SCAN_DIV-1 divider emitting a one-cycle tick at terminal count.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(SCAN_DIV);
    localparam logic [W-1:0] TC = W'(SCAN_DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == TC;
    assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/decoder3_8_reg.sv
// decoder3_8_reg: registered 3-to-8 active-low decoder with load strobe.
// Define DEC_SCAN_EN to build the auto-scan mode (SCAN state + scan_tick_gen).
module decoder3_8_reg
    import dec38_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       G1,
    input  logic [1:0] G2_n,
    input  logic [2:0] A,
    input  logic       GS,
    input  logic       ld,
    input  logic       mode,
    output logic [7:0] Y,
    output logic       vld,
    output logic [2:0] idx
);
    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] y_q;
    logic       vld_q;
    logic       en, scan_req, tick;
    assign en = G1 && (G2_n == 2'b00);
`ifdef DEC_SCAN_EN
    assign scan_req = mode;
    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_q != SCAN),
        .tick(tick)
    );
`else
    localparam int unused_scan_div = SCAN_DIV;
    logic unused_mode;
    assign unused_mode = mode;
    assign scan_req    = 1'b0;
    assign tick        = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (scan_req) begin
            state_d = SCAN;
            idx_d   = (state_q != SCAN) ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
        end else if (state_q == SCAN) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (ld) begin
            state_d = GS ? IDLE : HOLD;
            idx_d   = GS ? 3'd0 : ~A;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= Y_OFF;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= (state_d == IDLE) ? Y_OFF : one_cold(idx_d);
            vld_q   <= state_d != IDLE;
        end
    assign Y   = y_q;
    assign vld = vld_q;
    assign idx = idx_q;
endmodule

// File: tb/tb_decoder3_8_reg.sv
// tb_decoder3_8_reg: directed + randomized checks of decoder3_8_reg against a line-level model.
module tb_decoder3_8_reg;
    localparam int DIV = 4;
`ifdef DEC_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b0, G1 = 1'b0, GS = 1'b1, ld = 1'b0, mode = 1'b0;
    logic [1:0] G2_n = 2'b11;
    logic [2:0] A = 3'd0;
    logic [7:0] Y;
    logic       vld;
    logic [2:0] idx;
    int pass_cnt = 0, total = 0;
    int m_st = 0, m_idx = 0, m_cnt = 0;
    logic [11:0] exp_v;

    decoder3_8_reg #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .G1(G1), .G2_n(G2_n), .A(A), .GS(GS),
        .ld(ld), .mode(mode), .Y(Y), .vld(vld), .idx(idx)
    );

    always #5 clk = ~clk;

    // m_st: 0 = no line, 1 = latched line, 2 = scanning
    function automatic logic [11:0] exp_out();
        int line;
        line = (m_st == 0) ? -1 : m_idx;
        if (line < 0) return {8'hFF, 1'b0, 3'd0};
        return {8'(255 - (1 << line)), 1'b1, 3'(line)};
    endfunction

    task automatic model_edge();
        if (!(G1 == 1'b1 && G2_n == 2'b00)) begin
            m_st = 0; m_idx = 0;
        end else if (SCAN_BUILD && mode) begin
            if (m_st != 2) begin
                m_st = 2; m_idx = 0; m_cnt = 0;
            end else if (m_cnt == DIV - 1) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 8;
            end else m_cnt++;
        end else if (m_st == 2) begin
            m_st = 0; m_idx = 0;
        end else if (ld) begin
            if (GS) begin m_st = 0; m_idx = 0; end
            else begin m_st = 1; m_idx = 7 - int'(A); end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        exp_v = exp_out();
    endtask

    task automatic enable();
        G1 = 1'b1; G2_n = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; #1;
        m_st = 0; m_idx = 0; m_cnt = 0;
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL reset: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_hold();
        enable(); mode = 1'b0;
        ld = 1'b1; GS = 1'b0; A = 3'b000; step();
        total++;
        if ({Y, vld, idx} !== {8'h7F, 1'b1, 3'd7})
            $display("FAIL hold_load: got Y=%h vld=%b idx=%0d want Y=7f vld=1 idx=7", Y, vld, idx);
        else pass_cnt++;
        ld = 1'b0; A = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({Y, vld, idx} !== {8'h7F, 1'b1, 3'd7})
                $display("FAIL hold_ignore_a: got Y=%h vld=%b idx=%0d want Y=7f vld=1 idx=7", Y, vld, idx);
            else pass_cnt++;
        end
    endtask

    task automatic test_gs_invalid();
        ld = 1'b1; GS = 1'b1; A = 3'b101; step();
        ld = 1'b0;
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL gs_invalid: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        ld = 1'b1; GS = 1'b0; A = 3'b101; step();
        ld = 1'b0;
        total++;
        if ({Y, vld, idx} !== {8'hFB, 1'b1, 3'd2})
            $display("FAIL disable_pre: got Y=%h vld=%b idx=%0d want Y=fb vld=1 idx=2", Y, vld, idx);
        else pass_cnt++;
        G2_n = 2'b01; step();
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL disable: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
        enable();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
                $display("FAIL disable_discard: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
            else pass_cnt++;
        end
    endtask

    task automatic test_rst_mid_hold();
        ld = 1'b1; GS = 1'b0; A = 3'b011; step();
        ld = 1'b0;
        total++;
        if ({Y, vld, idx} !== {8'hEF, 1'b1, 3'd4})
            $display("FAIL rst_hold_pre: got Y=%h vld=%b idx=%0d want Y=ef vld=1 idx=4", Y, vld, idx);
        else pass_cnt++;
        #2 rst = 1'b1; #1;
        m_st = 0; m_idx = 0; m_cnt = 0;
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL rst_hold_async: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_mode_ignored();
        if (SCAN_BUILD) return;
        mode = 1'b1; ld = 1'b1; GS = 1'b0; A = 3'b110; step();
        ld = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            total++;
            if ({Y, vld, idx} !== {8'hFD, 1'b1, 3'd1})
                $display("FAIL mode_ignored c%0d: got Y=%h vld=%b idx=%0d want Y=fd vld=1 idx=1", i, Y, vld, idx);
            else pass_cnt++;
            step();
        end
        mode = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] seq [9];
        if (!SCAN_BUILD) return;
        seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        mode = 1'b1;
        for (int s = 0; s < 9; s++)
            for (int c = 0; c < DIV; c++) begin
                ld = 1'($urandom_range(0, 1)); GS = 1'($urandom_range(0, 1)); A = 3'($urandom);
                step();
                total++;
                if (Y !== seq[s] || {Y, vld, idx} !== exp_v)
                    $display("FAIL scan s%0d c%0d: got Y=%h vld=%b idx=%0d want Y=%h model=%h", s, c, Y, vld, idx, seq[s], exp_v);
                else pass_cnt++;
            end
        ld = 1'b0;
    endtask

    task automatic test_rst_mid_scan();
        int n = 0;
        if (!SCAN_BUILD) return;
        mode = 1'b0; step();
        mode = 1'b1;
        do begin step(); n++; end while (m_idx != 5 && n < 100);
        total++;
        if ({Y, vld, idx} !== {8'hDF, 1'b1, 3'd5})
            $display("FAIL scan_idx5: got Y=%h vld=%b idx=%0d want Y=df vld=1 idx=5", Y, vld, idx);
        else pass_cnt++;
        #2 rst = 1'b1; #1;
        m_st = 0; m_idx = 0; m_cnt = 0;
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL rst_scan_async: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
        step(); step();
        rst = 1'b0;
        step();
        total++;
        if ({Y, vld, idx} !== {8'hFE, 1'b1, 3'd0})
            $display("FAIL scan_restart: got Y=%h vld=%b idx=%0d want Y=fe vld=1 idx=0", Y, vld, idx);
        else pass_cnt++;
        mode = 1'b0; step();
        total++;
        if ({Y, vld, idx} !== {8'hFF, 1'b0, 3'd0})
            $display("FAIL scan_exit: got Y=%h vld=%b idx=%0d want Y=ff vld=0 idx=0", Y, vld, idx);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            G1   = 1'($urandom_range(0, 15) != 0);
            G2_n = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            mode = 1'($urandom_range(0, 9) < 7);
            ld   = 1'($urandom_range(0, 3) == 0);
            GS   = 1'($urandom_range(0, 4) == 0);
            A    = 3'($urandom);
            step();
            total++;
            if ({Y, vld, idx} !== exp_v || ($countones(~Y) > 1))
                $display("FAIL random c%0d: got Y=%h vld=%b idx=%0d want {Y,vld,idx}=%h", i, Y, vld, idx, exp_v);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_gs_invalid();
        test_disable();
        test_rst_mid_hold();
        test_mode_ignored();
        test_scan();
        test_rst_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
